fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Reads the current PC value and misaligned flag, issues a word read to instruction memory, and holds the returned instruction for decode under a valid/ready handshake.
- Generates the PC's step_pc edge, ctl select and offset: ctl=0 for sequential +4, ctl=1 for a relative jump supplied by execute.

Parameters:
- ADDR_W, 32, width of PC, memory address and jump offset.
- DATA_W, 32, instruction word width.
- TIMEOUT_CYC, 255, WAIT-state cycle limit before timeout fault (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  fetch enable; when low, halts in IDLE after the current transaction.
- pc_in  in  ADDR_W  current PC value.
- pc_misaligned  in  1  PC low bits nonzero.
- step_pc  out  1  one-cycle registered pulse; PC updates on its rising edge.
- pc_ctl  out  1  0 = increment by 4, 1 = add pc_offset.
- pc_offset  out  ADDR_W  jump offset to the PC adder.
- mem_req_valid  out  1  read request valid.
- mem_req_ready  in  1  memory accepts request.
- mem_addr  out  ADDR_W  request address.
- mem_rsp_valid  in  1  read data valid, one cycle.
- mem_rsp_data  in  DATA_W  read data.
- ir_valid  out  1  instruction available to decode.
- ir_ready  in  1  decode accepts instruction.
- ir_data  out  DATA_W  fetched instruction.
- ir_pc  out  ADDR_W  address the instruction was fetched from.
- jump_valid  in  1  one-cycle jump request from execute.
- jump_offset  in  ADDR_W  relative jump amount.
- fault  out  1  fetch halted on error.
- fault_code  out  2  01 = misaligned, 10 = timeout, 00 = none.
- fault_clr  in  1  clears fault; returns to IDLE.

Behaviour:
- Reset (async, rst_n low): state IDLE. All outputs 0. jump_pending 0, internal offset register 0.
- States are IDLE, REQ, WAIT, HOLD, STEP, SETTLE, FAULT.
- IDLE:
  - jump_pending → STEP with ctl=1.
  - Else if run and pc_misaligned → FAULT, code 01.
  - Else if run → REQ.
- REQ:
  - mem_req_valid=1, mem_addr=pc_in, both held stable until mem_req_ready.
  - A request is never withdrawn once asserted.
  - Handshake completes → WAIT.
- WAIT:
  - On mem_rsp_valid with jump_pending → discard data, go to STEP with ctl=1.
  - On mem_rsp_valid otherwise → latch ir_data=mem_rsp_data and ir_pc=mem_addr, set ir_valid=1, go to HOLD.
- HOLD:
  - ir_valid=1, ir_data and ir_pc stable.
  - jump_pending or jump_valid this cycle → ir_valid=0 next cycle, instruction flushed, STEP with ctl=1.
  - Else if ir_ready → ir_valid=0, STEP with ctl=0.
  - Jump wins over a simultaneous ir_ready; the instruction counts as not consumed.
- STEP:
  - step_pc=1 for exactly one cycle.
  - pc_ctl and pc_offset are set on entry and held unchanged through SETTLE.
  - When ctl=1, jump_pending clears on exit.
  - → SETTLE.
- SETTLE:
  - step_pc=0, one cycle for the PC to update.
  - → IDLE. A new request never uses the pre-step PC.
- jump_valid outside HOLD:
  - Sets jump_pending and latches jump_offset into the internal offset register.
  - A second jump before application overwrites it (latest wins).
- FAULT:
  - fault=1 and fault_code held; no requests issued; jump_valid ignored and jump_pending cleared.
  - fault_clr → IDLE next cycle with fault=0 and code 00.
- run low:
  - An in-progress REQ/WAIT/HOLD completes normally.
  - IDLE does not start a fetch; a pending jump is still applied.
- Minimum sequential fetch period with zero-wait memory and ir_ready high: 6 cycles (IDLE, REQ, WAIT, HOLD, STEP, SETTLE).
- Offset arithmetic belongs to the PC; this block never computes addresses.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT.
  - When TIMEOUT_CYC cycles pass without mem_rsp_valid → FAULT with code 10.
  - The counter clears on leaving WAIT and on reset.
  - A late response arriving in FAULT is ignored.
- Undefined: no counter, WAIT waits indefinitely, code 10 is never produced.

Test Plan:
- Sequential fetch:
  - Stimulus: pc model starts at 0, memory returns 0x11,0x22,0x33 with zero wait, ir_ready=1.
  - Response: ir_pc 0x0,0x4,0x8 with matching ir_data; step_pc pulses with pc_ctl=0; 6-cycle period.
- Decode backpressure:
  - Stimulus: ir_ready held low 10 cycles in HOLD.
  - Response: ir_valid and ir_data stable; no step_pc, no mem_req_valid until ir_ready rises.
- Jump during WAIT:
  - Stimulus: jump_valid with offset 0x40 while a response is outstanding from PC 0x8.
  - Response: response discarded (ir_valid stays 0); step_pc with pc_ctl=1, pc_offset=0x40; next mem_addr=0x48.
- Jump vs ir_ready in HOLD:
  - Stimulus: jump_valid and ir_ready in the same cycle.
  - Response: ctl=1 step only; no second step.
- Misaligned PC:
  - Stimulus: pc_in=0x2, pc_misaligned=1, run=1.
  - Response: no request; fault=1, code 01. fault_clr → IDLE, fault=0.
- Reset and timeout:
  - Stimulus: rst_n low mid-WAIT.
  - Response: immediately all outputs 0, state IDLE.
  - Stimulus (FETCH_TIMEOUT_EN): no response for 255 cycles.
  - Response: fault code 10.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: PC read, memory word fetch, IR hold for decode, PC step control.
// Optional WAIT-state timeout fault enabled by defining FETCH_TIMEOUT_EN.
`default_nettype none

module fetch_sequencer #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_misaligned,
  output logic              step_pc,
  output logic              pc_ctl,
  output logic [ADDR_W-1:0] pc_offset,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rsp_data,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_offset,
  output logic              fault,
  output logic [1:0]        fault_code,
  input  logic              fault_clr
);

  typedef enum logic [2:0] {
    S_IDLE, S_REQ, S_WAIT, S_HOLD, S_STEP, S_SETTLE, S_FAULT
  } state_e;

  state_e              state_q, state_d;
  logic                step_q, step_d;
  logic                ctl_q, ctl_d;
  logic [ADDR_W-1:0]   off_q, off_d;
  logic                req_q, req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                irv_q, irv_d;
  logic [DATA_W-1:0]   ird_q, ird_d;
  logic [ADDR_W-1:0]   irpc_q, irpc_d;
  logic                fault_q, fault_d;
  logic [1:0]          code_q, code_d;
  logic                jpend_q, jpend_d;
  logic [ADDR_W-1:0]   joff_q, joff_d;
  logic [ADDR_W-1:0]   jmp_off_c;
  logic                tmo_hit_c;

  // A jump arriving in the same cycle it is applied supersedes the stored offset.
  assign jmp_off_c = jump_valid ? jump_offset : joff_q;

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    ctl_d   = ctl_q;
    off_d   = off_q;
    req_d   = req_q;
    addr_d  = addr_q;
    irv_d   = irv_q;
    ird_d   = ird_q;
    irpc_d  = irpc_q;
    fault_d = fault_q;
    code_d  = code_q;
    jpend_d = jpend_q;
    joff_d  = joff_q;

    if (jump_valid && (state_q != S_FAULT)) begin
      jpend_d = 1'b1;
      joff_d  = jump_offset;
    end

    unique case (state_q)
      S_IDLE: begin
        if (jpend_q) begin
          state_d = S_STEP;
          step_d  = 1'b1;
          ctl_d   = 1'b1;
          off_d   = jmp_off_c;
        end else if (run && pc_misaligned) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'b01;
        end else if (run) begin
          state_d = S_REQ;
          req_d   = 1'b1;
          addr_d  = pc_in;
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          req_d   = 1'b0;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          if (jpend_q) begin
            state_d = S_STEP;
            step_d  = 1'b1;
            ctl_d   = 1'b1;
            off_d   = jmp_off_c;
          end else begin
            state_d = S_HOLD;
            irv_d   = 1'b1;
            ird_d   = mem_rsp_data;
            irpc_d  = addr_q;
          end
        end else if (tmo_hit_c) begin
          state_d = S_FAULT;
          fault_d = 1'b1;
          code_d  = 2'b10;
        end
      end
      S_HOLD: begin
        // A jump flushes the held instruction even if decode accepts it this cycle.
        if (jpend_q || jump_valid) begin
          state_d = S_STEP;
          irv_d   = 1'b0;
          step_d  = 1'b1;
          ctl_d   = 1'b1;
          off_d   = jmp_off_c;
        end else if (ir_ready) begin
          state_d = S_STEP;
          irv_d   = 1'b0;
          step_d  = 1'b1;
          ctl_d   = 1'b0;
          off_d   = '0;
        end
      end
      S_STEP: begin
        state_d = S_SETTLE;
        if (ctl_q && !jump_valid) jpend_d = 1'b0;
      end
      S_SETTLE: begin
        state_d = S_IDLE;
        ctl_d   = 1'b0;
        off_d   = '0;
      end
      S_FAULT: begin
        jpend_d = 1'b0;
        joff_d  = joff_q;
        if (fault_clr) begin
          state_d = S_IDLE;
          fault_d = 1'b0;
          code_d  = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);
  logic [TmoW-1:0] tmo_q, tmo_d;

  // Counts consecutive WAIT cycles; zero whenever WAIT is left.
  always_comb begin
    tmo_d = '0;
    if ((state_q == S_WAIT) && (state_d == S_WAIT)) tmo_d = tmo_q + TmoW'(1);
  end

  assign tmo_hit_c = (state_q == S_WAIT) && (tmo_q == TmoW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^32'(TIMEOUT_CYC);
  assign tmo_hit_c      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      step_q  <= 1'b0;
      ctl_q   <= 1'b0;
      off_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      irv_q   <= 1'b0;
      ird_q   <= '0;
      irpc_q  <= '0;
      fault_q <= 1'b0;
      code_q  <= 2'b00;
      jpend_q <= 1'b0;
      joff_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ctl_q   <= ctl_d;
      off_q   <= off_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      irv_q   <= irv_d;
      ird_q   <= ird_d;
      irpc_q  <= irpc_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      jpend_q <= jpend_d;
      joff_q  <= joff_d;
    end
  end

  assign step_pc       = step_q;
  assign pc_ctl        = ctl_q;
  assign pc_offset     = off_q;
  assign mem_req_valid = req_q;
  assign mem_addr      = addr_q;
  assign ir_valid      = irv_q;
  assign ir_data       = ird_q;
  assign ir_pc         = irpc_q;
  assign fault         = fault_q;
  assign fault_code    = code_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: bench-owned PC and memory, transaction-level reference model,
// directed scenarios followed by randomized traffic.
module tb_fetch_sequencer;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              run = 1'b0;
  logic [ADDR_W-1:0] pc_in;
  logic              pc_misaligned;
  logic              step_pc, pc_ctl, mem_req_valid, ir_valid, fault;
  logic [ADDR_W-1:0] pc_offset, mem_addr, ir_pc;
  logic              mem_req_ready = 1'b0;
  logic              mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0] mem_rsp_data = '0;
  logic [DATA_W-1:0] ir_data;
  logic              ir_ready = 1'b0;
  logic              jump_valid = 1'b0;
  logic [ADDR_W-1:0] jump_offset = '0;
  logic [1:0]        fault_code;
  logic              fault_clr = 1'b0;

  fetch_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .pc_in(pc_in), .pc_misaligned(pc_misaligned),
    .step_pc(step_pc), .pc_ctl(pc_ctl), .pc_offset(pc_offset),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data),
    .ir_valid(ir_valid), .ir_ready(ir_ready), .ir_data(ir_data), .ir_pc(ir_pc),
    .jump_valid(jump_valid), .jump_offset(jump_offset),
    .fault(fault), .fault_code(fault_code), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Bench-owned PC register and reference state.
  logic [31:0] pc_model = '0;
  logic [31:0] pc_reset_val = '0;
  logic [31:0] jm_off = '0;
  bit          jm_pend = 0;
  bit          consumed = 0;
  int          exp_irv = -1;
  logic [31:0] exp_irpc = '0;
  logic [31:0] acc_pc = '0;
  bit          prev_stall = 0;
  logic [31:0] prev_addr = '0;
  int          cyc = 0;
  int          last_step_cyc = -1;
  bit          chk_period = 0;
  int          n_step0 = 0, n_step1 = 0, n_req = 0, n_cons = 0;
  logic [31:0] cons_pc[$];
  logic [31:0] cons_data[$];

  // Memory responder state.
  bit          mem_mute = 0;
  bit          mem_rand = 0;
  bit          rsp_busy = 0;
  int          rsp_dly = 0;
  logic [31:0] rsp_addr = '0;

  assign pc_in         = pc_model;
  assign pc_misaligned = |pc_model[1:0];

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return 32'h11 * ((a >> 2) + 32'd1);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle: drive memory inputs for this cycle, then score this cycle's outputs and inputs.
  always @(negedge clk) begin
    if (!rst_n) begin
      pc_model      = pc_reset_val;
      jm_pend       = 0;
      jm_off        = '0;
      consumed      = 0;
      exp_irv       = -1;
      prev_stall    = 0;
      rsp_busy      = 0;
      last_step_cyc = -1;
      mem_rsp_valid = 1'b0;
      mem_req_ready = 1'b0;
    end else begin
      cyc++;
      mem_rsp_valid = 1'b0;
      if (rsp_busy && !mem_mute) begin
        if (rsp_dly == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_fn(rsp_addr);
          rsp_busy      = 0;
        end else begin
          rsp_dly--;
        end
      end
      mem_req_ready = mem_rand ? ($urandom_range(0, 2) != 0) : 1'b1;

      if (exp_irv >= 0) begin
        check("ir_valid_after_rsp", 64'(ir_valid), 64'(exp_irv));
        if (exp_irv == 1) begin
          check("ir_pc_latch", 64'(ir_pc), 64'(exp_irpc));
          check("ir_data_latch", 64'(ir_data), 64'(mem_fn(exp_irpc)));
        end
        exp_irv = -1;
      end
      if (prev_stall) check("req_hold", {31'd0, mem_req_valid, mem_addr}, {31'd0, 1'b1, prev_addr});

      if (step_pc) begin
        check("step_ctl", 64'(pc_ctl), 64'(jm_pend));
        if (jm_pend) begin
          check("step_off", 64'(pc_offset), 64'(jm_off));
          pc_model = pc_model + jm_off;
          jm_pend  = 0;
          n_step1++;
        end else begin
          check("step_consumed", 64'(consumed), 64'd1);
          pc_model = pc_model + 32'd4;
          n_step0++;
          if (chk_period && last_step_cyc >= 0) check("step_period", 64'(cyc - last_step_cyc), 64'd6);
          last_step_cyc = cyc;
        end
        consumed = 0;
      end

      if (mem_req_valid && mem_req_ready) begin
        check("req_addr", 64'(mem_addr), 64'(pc_model));
        n_req++;
        acc_pc   = pc_model;
        rsp_busy = 1;
        rsp_addr = mem_addr;
        rsp_dly  = mem_rand ? int'($urandom_range(0, 3)) : 0;
      end
      prev_stall = mem_req_valid && !mem_req_ready;
      prev_addr  = mem_addr;

      if (mem_rsp_valid && !fault) begin
        exp_irv  = jm_pend ? 0 : 1;
        exp_irpc = acc_pc;
      end

      if (ir_valid && ir_ready && !jump_valid && !jm_pend) begin
        check("cons_pc", 64'(ir_pc), 64'(acc_pc));
        check("cons_data", 64'(ir_data), 64'(mem_fn(acc_pc)));
        consumed = 1;
        n_cons++;
        cons_pc.push_back(ir_pc);
        cons_data.push_back(ir_data);
      end

      if (fault) jm_pend = 0;
      else if (jump_valid) begin
        jm_pend = 1;
        jm_off  = jump_offset;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [31:0] pc0);
    rst_n = 1'b0; pc_reset_val = pc0; run = 1'b0; ir_ready = 1'b0;
    jump_valid = 1'b0; fault_clr = 1'b0; mem_mute = 0; mem_rand = 0;
    tick(2);
    check("rst_ctl", {58'd0, step_pc, pc_ctl, mem_req_valid, ir_valid, fault_code}, 64'd0);
    check("rst_fault", 64'(fault), 64'd0);
    check("rst_off_addr", {pc_offset, mem_addr}, 64'd0);
    check("rst_ir", {ir_data, ir_pc}, 64'd0);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_req(input string tag);
    int r0, t;
    r0 = n_req; t = 0;
    while (n_req == r0 && t < 30) begin tick(1); t++; end
    check(tag, 64'(n_req - r0), 64'd1);
  endtask

  initial begin
    int t, s0, s1, r0;
    bit seen;

    // Sequential fetch: zero-wait memory, decode always ready.
    do_reset(32'h0);
    chk_period = 1; ir_ready = 1'b1; run = 1'b1;
    t = 0;
    while (n_cons < 3 && t < 40) begin tick(1); t++; end
    run = 1'b0;
    tick(4);
    chk_period = 0;
    check("seq_count", 64'(cons_pc.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < cons_pc.size()) begin
        check("seq_pc", 64'(cons_pc[i]), 64'(4 * i));
        check("seq_data", 64'(cons_data[i]), 64'(32'h11 * (i + 1)));
      end
    end
    check("seq_steps", 64'(n_step0), 64'd3);

    // Decode backpressure: instruction held for 10 cycles.
    ir_ready = 1'b0; run = 1'b1;
    t = 0;
    while (!ir_valid && t < 20) begin tick(1); t++; end
    run = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", {29'd0, ir_valid, step_pc, mem_req_valid, ir_data},
            {29'd0, 1'b1, 1'b0, 1'b0, mem_fn(32'hC)});
      tick(1);
    end
    ir_ready = 1'b1;
    tick(1);
    ir_ready = 1'b0;
    check("bp_step", {63'd0, step_pc}, 64'd1);
    tick(4);

    // Jump while a response from PC 0x8 is outstanding.
    do_reset(32'h8);
    mem_mute = 1; run = 1'b1; ir_ready = 1'b1;
    wait_req("jw_req");
    s1 = n_step1;
    jump_valid = 1'b1; jump_offset = 32'h40;
    tick(1);
    jump_valid = 1'b0; mem_mute = 0;
    t = 0; seen = 0;
    while (!mem_req_valid && t < 20) begin seen |= ir_valid; tick(1); t++; end
    check("jw_flush", 64'(seen), 64'd0);
    check("jw_next_addr", {31'd0, mem_req_valid, mem_addr}, {31'd0, 1'b1, 32'h48});
    check("jw_step1", 64'(n_step1 - s1), 64'd1);
    run = 1'b0;
    tick(10);

    // Jump and ir_ready together in HOLD: one ctl=1 step only.
    ir_ready = 1'b0; run = 1'b1;
    t = 0;
    while (!ir_valid && t < 20) begin tick(1); t++; end
    run = 1'b0;
    s0 = n_step0; s1 = n_step1;
    jump_valid = 1'b1; jump_offset = 32'h100; ir_ready = 1'b1;
    tick(1);
    jump_valid = 1'b0; ir_ready = 1'b0;
    tick(8);
    check("jr_ctl1", 64'(n_step1 - s1), 64'd1);
    check("jr_ctl0", 64'(n_step0 - s0), 64'd0);

    // Misaligned PC faults without a request.
    do_reset(32'h2);
    r0 = n_req; run = 1'b1;
    tick(3);
    check("mis_fault", {61'd0, fault, fault_code}, {61'd0, 1'b1, 2'b01});
    check("mis_noreq", {31'd0, mem_req_valid, 32'(n_req - r0)}, 64'd0);
    run = 1'b0; fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("mis_clr", {61'd0, fault, fault_code}, 64'd0);

    // Asynchronous reset in the middle of WAIT.
    do_reset(32'h20);
    mem_mute = 1; run = 1'b1;
    wait_req("rw_req");
    tick(2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_ctl", {57'd0, step_pc, pc_ctl, mem_req_valid, ir_valid, fault, fault_code}, 64'd0);
    check("async_rst_bus", {pc_offset, mem_addr}, 64'd0);
    check("async_rst_ir", {ir_data, ir_pc}, 64'd0);

    // WAIT with no response: timeout fault only when enabled.
    do_reset(32'h30);
    mem_mute = 1; run = 1'b1; ir_ready = 1'b1;
    wait_req("tmo_req");
    tick(254);
    check("tmo_before", {61'd0, fault, fault_code}, 64'd0);
    tick(1);
`ifdef FETCH_TIMEOUT_EN
    check("tmo_fault", {61'd0, fault, fault_code}, {61'd0, 1'b1, 2'b10});
    run = 1'b0; mem_mute = 0;
    tick(3);
    check("tmo_late_rsp", {60'd0, ir_valid, fault, fault_code}, {60'd0, 1'b0, 1'b1, 2'b10});
    fault_clr = 1'b1;
    tick(1);
    fault_clr = 1'b0;
    check("tmo_clr", {61'd0, fault, fault_code}, 64'd0);
`else
    check("no_tmo", {61'd0, fault, fault_code}, 64'd0);
    run = 1'b0; mem_mute = 0;
    tick(8);
    check("no_tmo_done", {61'd0, fault, fault_code}, 64'd0);
`endif

    // Randomized traffic checked by the reference model.
    do_reset(32'h0);
    mem_rand = 1;
    r0 = n_cons;
    for (int i = 0; i < 3000; i++) begin
      run         = ($urandom_range(0, 7) != 0);
      ir_ready    = ($urandom_range(0, 9) < 7);
      jump_valid  = ($urandom_range(0, 11) == 0);
      jump_offset = 32'($urandom_range(0, 255)) << 2;
      tick(1);
    end
    jump_valid = 1'b0; run = 1'b0; ir_ready = 1'b1;
    tick(20);
    check("rnd_progress", 64'((n_cons - r0) > 30), 64'd1);
    check("rnd_no_fault", 64'(fault), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
